z2_autoconfig_master: RTL and testbench

Hardware Zorro II AutoConfig initiator for the 68020-side bus. After a START pulse it walks the $E80000 configuration window, issues byte-wide 68020 bus cycles (AS20/DS20/RW20/SIZ) to read each board's type, product and manufacturer nibbles, then either assigns a base address or shuts the board up. It loops until an empty slot or MAX_BOARDS, and serves as the bring-up and verification counterpart to the fast-RAM AutoConfig responder.

---
 rtl/z2_autoconfig_master_if.sv | 13 +
 rtl/z2_autoconfig_master.sv | 241 ++++++++++++++++++++++++
 tb/tb_z2_autoconfig_master.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/z2_autoconfig_master_if.sv
// Zorro II 68020-side bus signals driven by the AutoConfig initiator.
// The data bus stays a plain inout port on the master because it is shared
// with the responder.
interface z2_autoconfig_master_if;
    logic [23:0] A;
    logic [1:0]  SIZ;
    logic        AS20;
    logic        DS20;
    logic        RW20;

    modport master (output A, SIZ, AS20, DS20, RW20);
    modport slave  (input  A, SIZ, AS20, DS20, RW20);
endinterface

// File: rtl/z2_autoconfig_master.sv
// Zorro II AutoConfig initiator: walks the $E80000 window and reads each
// board's ID nibbles. It then gives the first 8 MB memory board a base
// address and shuts up every other board.
//
// state     | meaning
// ----------|----------------------------------------------------------
// S_IDLE    | waiting for START
// S_ADDR    | address, RW20 and write data driven, strobes high
// S_AS_LOW  | AS20 asserted
// S_DS_LOW  | DS20 asserted for DS_CYCLES clocks; read sampled on last
// S_RELEASE | strobes released, address/data held one more clock
// S_DECIDE  | classify the board from the eight nibbles read
// S_FINISH  | DONE pulse, BUSY low
module z2_autoconfig_master #(
    parameter int DS_CYCLES  = 3,
    parameter int MAX_BOARDS = 4
) (
    input  logic                          CLKCPU,
    input  logic                          RESET,
    input  logic                          START,
    input  logic [3:0]                    BASE,
    z2_autoconfig_master_if.master        bus,
    inout  wire  [7:0]                    D,
    output logic                          BUSY,
    output logic                          DONE,
    output logic [2:0]                    BOARDS,
    output logic                          MEM_CONFIGURED,
    output logic [7:0]                    ER_TYPE,
    output logic [7:0]                    ER_PRODUCT,
    output logic [15:0]                   ER_MANUF
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ADDR    = 3'd1;
    localparam logic [2:0] S_AS_LOW  = 3'd2;
    localparam logic [2:0] S_DS_LOW  = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;
    localparam logic [2:0] S_DECIDE  = 3'd5;
    localparam logic [2:0] S_FINISH  = 3'd6;

    localparam logic [23:0]    CFG_BASE = 24'hE80000;
    localparam int             DSW      = (DS_CYCLES > 2) ? $clog2(DS_CYCLES) : 1;
    localparam logic [DSW-1:0] DS_LOAD  = DSW'(DS_CYCLES - 1);
    localparam logic [2:0]     MAX_B    = 3'(MAX_BOARDS);

    // Read list: index 0-3 -> $00..$06, index 4-7 -> $10..$16.
    function automatic logic [23:0] rd_addr(input logic [2:0] i);
        return CFG_BASE | {19'd0, i[2], 1'b0, i[1:0], 1'b0};
    endfunction

    logic [2:0]     state_q, state_d;
    logic [2:0]     idx_q, idx_d;
    logic [DSW-1:0] ds_cnt_q, ds_cnt_d;
    logic [23:0]    a_q, a_d;
    logic           as_n_q, as_n_d, ds_n_q, ds_n_d, rw_q, rw_d;
    logic           d_oe_q, d_oe_d;
    logic [7:0]     d_out_q, d_out_d;
    logic           is_wr_q, is_wr_d, wr_assign_q, wr_assign_d;
    logic           busy_q, busy_d, done_q, done_d, mem_cfg_q, mem_cfg_d;
    logic [2:0]     boards_q, boards_d;
    logic [7:0]     er_type_q, er_type_d, er_product_q, er_product_d;
    logic [15:0]    er_manuf_q, er_manuf_d;
    logic [3:0]     nib;
    logic           assign_ok;
    logic           unused_d_lo;

    assign nib         = D[7:4];
    assign unused_d_lo = ^D[3:0];
    // Only an unconfigured-so-far 8 MB memory board gets the base address.
    assign assign_ok   = (er_type_q[7:6] == 2'b11) && er_type_q[5] &&
                         (er_type_q[2:0] == 3'b000) && !mem_cfg_q;

    // Next-state and bus-cycle sequencing.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        ds_cnt_d     = ds_cnt_q;
        a_d          = a_q;
        as_n_d       = as_n_q;
        ds_n_d       = ds_n_q;
        rw_d         = rw_q;
        d_oe_d       = d_oe_q;
        d_out_d      = d_out_q;
        is_wr_d      = is_wr_q;
        wr_assign_d  = wr_assign_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        boards_d     = boards_q;
        mem_cfg_d    = mem_cfg_q;
        er_type_d    = er_type_q;
        er_product_d = er_product_q;
        er_manuf_d   = er_manuf_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d      = S_ADDR;
                    idx_d        = 3'd0;
                    is_wr_d      = 1'b0;
                    wr_assign_d  = 1'b0;
                    a_d          = rd_addr(3'd0);
                    rw_d         = 1'b1;
                    d_oe_d       = 1'b0;
                    busy_d       = 1'b1;
                    boards_d     = 3'd0;
                    mem_cfg_d    = 1'b0;
                    er_type_d    = 8'h00;
                    er_product_d = 8'h00;
                    er_manuf_d   = 16'h0000;
                end
            end
            S_ADDR: begin
                state_d = S_AS_LOW;
                as_n_d  = 1'b0;
            end
            S_AS_LOW: begin
                state_d  = S_DS_LOW;
                ds_n_d   = 1'b0;
                ds_cnt_d = DS_LOAD;
            end
            S_DS_LOW: begin
                if (ds_cnt_q == '0) begin
                    state_d = S_RELEASE;
                    as_n_d  = 1'b1;
                    ds_n_d  = 1'b1;
                    if (!is_wr_q) begin
                        // Type nibbles are stored true, all others inverted.
                        case (idx_q)
                            3'd0:    er_type_d[7:4]    = nib;
                            3'd1:    er_type_d[3:0]    = nib;
                            3'd2:    er_product_d[7:4] = ~nib;
                            3'd3:    er_product_d[3:0] = ~nib;
                            3'd4:    er_manuf_d[15:12] = ~nib;
                            3'd5:    er_manuf_d[11:8]  = ~nib;
                            3'd6:    er_manuf_d[7:4]   = ~nib;
                            default: er_manuf_d[3:0]   = ~nib;
                        endcase
                    end
                end else begin
                    ds_cnt_d = ds_cnt_q - DSW'(1);
                end
            end
            S_RELEASE: begin
                if (is_wr_q) begin
                    d_oe_d   = 1'b0;
                    is_wr_d  = 1'b0;
                    rw_d     = 1'b1;
                    boards_d = boards_q + 3'd1;
                    if (wr_assign_q) mem_cfg_d = 1'b1;
                    if (boards_q + 3'd1 == MAX_B) begin
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_ADDR;
                        idx_d   = 3'd0;
                        a_d     = rd_addr(3'd0);
                    end
                end else if (idx_q == 3'd7) begin
                    state_d = S_DECIDE;
                end else begin
                    state_d = S_ADDR;
                    idx_d   = idx_q + 3'd1;
                    a_d     = rd_addr(idx_q + 3'd1);
                end
            end
            S_DECIDE: begin
                if (er_type_q == 8'hFF || er_type_q == 8'h00) begin
                    state_d = S_FINISH;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d     = S_ADDR;
                    is_wr_d     = 1'b1;
                    wr_assign_d = assign_ok;
                    a_d         = assign_ok ? (CFG_BASE | 24'h48) : (CFG_BASE | 24'h4C);
                    d_out_d     = assign_ok ? {BASE, 4'h0} : 8'h00;
                    rw_d        = 1'b0;
                    d_oe_d      = 1'b1;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset releases the bus immediately.
    always_ff @(posedge CLKCPU or negedge RESET) begin
        if (!RESET) begin
            state_q      <= S_IDLE;
            idx_q        <= 3'd0;
            ds_cnt_q     <= '0;
            a_q          <= 24'h0;
            as_n_q       <= 1'b1;
            ds_n_q       <= 1'b1;
            rw_q         <= 1'b1;
            d_oe_q       <= 1'b0;
            d_out_q      <= 8'h00;
            is_wr_q      <= 1'b0;
            wr_assign_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            boards_q     <= 3'd0;
            mem_cfg_q    <= 1'b0;
            er_type_q    <= 8'h00;
            er_product_q <= 8'h00;
            er_manuf_q   <= 16'h0000;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            ds_cnt_q     <= ds_cnt_d;
            a_q          <= a_d;
            as_n_q       <= as_n_d;
            ds_n_q       <= ds_n_d;
            rw_q         <= rw_d;
            d_oe_q       <= d_oe_d;
            d_out_q      <= d_out_d;
            is_wr_q      <= is_wr_d;
            wr_assign_q  <= wr_assign_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            boards_q     <= boards_d;
            mem_cfg_q    <= mem_cfg_d;
            er_type_q    <= er_type_d;
            er_product_q <= er_product_d;
            er_manuf_q   <= er_manuf_d;
        end
    end

    assign bus.A          = a_q;
    assign bus.SIZ        = 2'b01;
    assign bus.AS20       = as_n_q;
    assign bus.DS20       = ds_n_q;
    assign bus.RW20       = rw_q;
    assign D              = d_oe_q ? d_out_q : 8'hzz;
    assign BUSY           = busy_q;
    assign DONE           = done_q;
    assign BOARDS         = boards_q;
    assign MEM_CONFIGURED = mem_cfg_q;
    assign ER_TYPE        = er_type_q;
    assign ER_PRODUCT     = er_product_q;
    assign ER_MANUF       = er_manuf_q;
endmodule

// File: tb/tb_z2_autoconfig_master.sv
// Bench for z2_autoconfig_master: a chained AutoConfig responder model,
// a scoreboard of expected write cycles / DONE reports, and a bus monitor.
module tb_z2_autoconfig_master;
    localparam int DS_CYCLES  = 3;
    localparam int MAX_BOARDS = 4;

    logic        CLKCPU = 1'b0;
    logic        RESET  = 1'b0;
    logic        START  = 1'b0;
    logic [3:0]  BASE   = 4'h2;
    wire  [7:0]  D;
    logic        BUSY, DONE, MEM_CONFIGURED;
    logic [2:0]  BOARDS;
    logic [7:0]  ER_TYPE, ER_PRODUCT;
    logic [15:0] ER_MANUF;

    z2_autoconfig_master_if bus_if ();

    z2_autoconfig_master #(.DS_CYCLES(DS_CYCLES), .MAX_BOARDS(MAX_BOARDS)) dut (
        .CLKCPU(CLKCPU), .RESET(RESET), .START(START), .BASE(BASE),
        .bus(bus_if), .D(D), .BUSY(BUSY), .DONE(DONE), .BOARDS(BOARDS),
        .MEM_CONFIGURED(MEM_CONFIGURED), .ER_TYPE(ER_TYPE),
        .ER_PRODUCT(ER_PRODUCT), .ER_MANUF(ER_MANUF)
    );

    always #5 CLKCPU = ~CLKCPU;

    int unsigned cyc = 0;
    always @(posedge CLKCPU) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- responder model ----------------
    // Nibbles as seen on D[7:4] for $00,$02,$04,$06,$10,$12,$14,$16 (MSB first).
    localparam logic [31:0] NIB_FASTRAM = 32'hE0FDEC27;
    localparam logic [31:0] NIB_IO_C1   = 32'hC1FFFFFF;
    localparam logic [31:0] NIB_TYPE00  = 32'h00FFFFFF;

    logic [31:0] board_nibs [4];
    int          num_boards  = 0;
    bit          repeat_last = 0;
    int          cur_board   = 0;
    logic [31:0] cur_word;
    logic [2:0]  rd_idx;
    logic [3:0]  resp_nib;
    logic        resp_en;
    logic        r_prev_ds = 1'b1;

    always_comb begin
        cur_word = 32'hFFFFFFFF;
        if (cur_board < num_boards)
            cur_word = board_nibs[cur_board];
        else if (repeat_last && num_boards > 0)
            cur_word = board_nibs[num_boards-1];
        rd_idx   = {bus_if.A[4], bus_if.A[2:1]};
        resp_nib = 4'(cur_word >> ((7 - int'(rd_idx)) * 4));
    end

    // An empty slot reads as pulled-up 8'hFF.
    assign resp_en = !bus_if.AS20 && bus_if.RW20 && (bus_if.A[23:16] == 8'hE8);
    assign D       = resp_en ? {resp_nib, 4'hF} : 8'hzz;

    // Each board leaves the chain once it has been written (configured or shut up).
    always @(negedge CLKCPU) begin
        if (!RESET) r_prev_ds = 1'b1;
        else begin
            if (r_prev_ds && !bus_if.DS20 && !bus_if.RW20) cur_board++;
            r_prev_ds = bus_if.DS20;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          is_done;
        logic [23:0] addr;
        logic [7:0]  data;
        logic [7:0]  et;
        logic [7:0]  ep;
        logic [15:0] em;
        logic [2:0]  boards;
        logic        mem;
    } exp_t;

    exp_t sb[$];
    int unsigned start_cyc         = 0;
    bit          first_as_pending  = 0;
    int unsigned exp_done_lat      = 0;
    int          done_count        = 0;

    task automatic push_wr(input logic [23:0] addr, input logic [7:0] data,
                           input logic [7:0] et, input logic [7:0] ep, input logic [15:0] em);
        exp_t e;
        e.is_done = 0; e.addr = addr; e.data = data; e.et = et; e.ep = ep; e.em = em;
        e.boards = 3'd0; e.mem = 1'b0;
        sb.push_back(e);
    endtask

    task automatic push_done(input logic [2:0] boards, input logic mem,
                             input logic [7:0] et, input logic [7:0] ep, input logic [15:0] em);
        exp_t e;
        e.is_done = 1; e.addr = 24'h0; e.data = 8'h0; e.et = et; e.ep = ep; e.em = em;
        e.boards = boards; e.mem = mem;
        sb.push_back(e);
    endtask

    // ---------------- monitor ----------------
    logic        m_prev_as = 1'b1;
    logic        m_prev_ds = 1'b1;
    logic [23:0] m_prev_a  = 24'h0;
    int          m_ds_cnt  = 0;

    always @(negedge CLKCPU) begin
        exp_t e;
        if (!RESET) begin
            m_prev_as = 1'b1;
            m_prev_ds = 1'b1;
            m_ds_cnt  = 0;
        end else begin
            if (m_prev_as && !bus_if.AS20) begin
                check("siz_byte", 32'(bus_if.SIZ), 32'h1);
                check("addr_stable_before_as", 32'(bus_if.A), 32'(m_prev_a));
                if (first_as_pending) begin
                    check("start_to_as_latency", cyc - start_cyc, 32'd2);
                    first_as_pending = 0;
                end
            end
            if (!bus_if.DS20) m_ds_cnt++;
            if (!m_prev_ds && bus_if.DS20) begin
                check("ds_low_width", 32'(m_ds_cnt), 32'(DS_CYCLES));
                m_ds_cnt = 0;
            end
            if (m_prev_ds && !bus_if.DS20 && !bus_if.RW20) begin
                if (sb.size() == 0 || sb[0].is_done) begin
                    tests++; fails++;
                    $display("FAIL unexpected_write: addr %0h data %0h, expected no write", bus_if.A, D);
                end else begin
                    e = sb.pop_front();
                    check("wr_addr", 32'(bus_if.A), 32'(e.addr));
                    check("wr_data", 32'(D), 32'(e.data));
                    check("wr_er_type", 32'(ER_TYPE), 32'(e.et));
                    check("wr_er_product", 32'(ER_PRODUCT), 32'(e.ep));
                    check("wr_er_manuf", 32'(ER_MANUF), 32'(e.em));
                end
            end
            if (DONE) begin
                done_count++;
                check("busy_low_at_done", 32'(BUSY), 32'h0);
                if (sb.size() == 0 || !sb[0].is_done) begin
                    tests++; fails++;
                    $display("FAIL unexpected_done: boards %0d, expected a write or nothing", BOARDS);
                end else begin
                    e = sb.pop_front();
                    check("done_boards", 32'(BOARDS), 32'(e.boards));
                    check("done_mem_cfg", 32'(MEM_CONFIGURED), 32'(e.mem));
                    check("done_er_type", 32'(ER_TYPE), 32'(e.et));
                    check("done_er_product", 32'(ER_PRODUCT), 32'(e.ep));
                    check("done_er_manuf", 32'(ER_MANUF), 32'(e.em));
                    if (exp_done_lat != 0)
                        check("start_to_done_latency", cyc - start_cyc, exp_done_lat);
                end
            end
        end
        m_prev_as = bus_if.AS20;
        m_prev_ds = bus_if.DS20;
        m_prev_a  = bus_if.A;
    end

    // ---------------- stimulus ----------------
    task automatic start_run();
        @(negedge CLKCPU);
        START            = 1'b1;
        start_cyc        = cyc;
        first_as_pending = 1;
        @(negedge CLKCPU);
        START = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int base = done_count;
        int n = 0;
        while (done_count == base && n < budget) begin
            @(negedge CLKCPU);
            n++;
        end
        if (done_count == base) check("done_timeout", 32'h0, 32'h1);
        repeat (2) @(negedge CLKCPU);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
    endtask

    task automatic setup_chain(input logic [31:0] b0, input logic [31:0] b1,
                               input int n, input bit rep);
        board_nibs[0] = b0;
        board_nibs[1] = b1;
        num_boards    = n;
        repeat_last   = rep;
        cur_board     = 0;
    endtask

    initial begin
        int n;
        repeat (3) @(negedge CLKCPU);
        check("rst_A", 32'(bus_if.A), 32'h0);
        check("rst_SIZ", 32'(bus_if.SIZ), 32'h1);
        check("rst_strobes_rw", {29'd0, bus_if.AS20, bus_if.DS20, bus_if.RW20}, 32'h7);
        check("rst_busy_done", {30'd0, BUSY, DONE}, 32'h0);
        check("rst_boards_mem", {28'd0, BOARDS, MEM_CONFIGURED}, 32'h0);
        check("rst_er", {ER_TYPE, ER_PRODUCT, ER_MANUF}, 32'h0);
        RESET = 1'b1;
        repeat (2) @(negedge CLKCPU);

        // Fast-RAM board followed by an empty slot.
        setup_chain(NIB_FASTRAM, 32'hFFFFFFFF, 1, 0);
        push_wr(24'hE80048, 8'h20, 8'hE0, 8'h02, 16'h13D8);
        push_done(3'd1, 1'b1, 8'hFF, 8'h00, 16'h0000);
        exp_done_lat = 105;
        start_run();
        wait_done(400);
        exp_done_lat = 0;

        // Empty bus; START presented during the DONE clock must be ignored.
        setup_chain(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
        push_done(3'd0, 1'b0, 8'hFF, 8'h00, 16'h0000);
        start_run();
        n = 0;
        while (!DONE && n < 200) begin
            @(negedge CLKCPU);
            n++;
        end
        check("empty_done_seen", 32'(DONE), 32'h1);
        START = 1'b1;
        @(negedge CLKCPU);
        START = 1'b0;
        repeat (4) @(negedge CLKCPU);
        check("start_at_done_ignored", {30'd0, BUSY, bus_if.AS20}, 32'h1);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);

        // Type 8'h00 also ends the run uncounted.
        setup_chain(NIB_TYPE00, 32'hFFFFFFFF, 1, 0);
        push_done(3'd0, 1'b0, 8'h00, 8'h00, 16'h0000);
        start_run();
        wait_done(200);

        // Two 8 MB memory boards: only the first gets a base address.
        setup_chain(NIB_FASTRAM, NIB_FASTRAM, 2, 0);
        push_wr(24'hE80048, 8'h20, 8'hE0, 8'h02, 16'h13D8);
        push_wr(24'hE8004C, 8'h00, 8'hE0, 8'h02, 16'h13D8);
        push_done(3'd2, 1'b1, 8'hFF, 8'h00, 16'h0000);
        start_run();
        wait_done(400);

        // Endless chain of non-memory boards stops at MAX_BOARDS.
        setup_chain(NIB_IO_C1, 32'hFFFFFFFF, 1, 1);
        for (int i = 0; i < MAX_BOARDS; i++)
            push_wr(24'hE8004C, 8'h00, 8'hC1, 8'h00, 16'h0000);
        push_done(3'(MAX_BOARDS), 1'b0, 8'hC1, 8'h00, 16'h0000);
        start_run();
        wait_done(600);

        // Reset during DS_LOW of the third read, then a normal run.
        setup_chain(NIB_FASTRAM, 32'hFFFFFFFF, 1, 0);
        start_run();
        n = 0;
        while (cyc < start_cyc + 16 && n < 100) begin
            @(negedge CLKCPU);
            n++;
        end
        check("third_read_ds_low", 32'(bus_if.DS20), 32'h0);
        #2 RESET = 1'b0;
        #1;
        check("midrun_rst_strobes_rw", {29'd0, bus_if.AS20, bus_if.DS20, bus_if.RW20}, 32'h7);
        check("midrun_rst_busy_done", {30'd0, BUSY, DONE}, 32'h0);
        first_as_pending = 0;
        repeat (2) @(negedge CLKCPU);
        RESET = 1'b1;
        repeat (3) @(negedge CLKCPU);
        check("post_rst_idle", {30'd0, BUSY, bus_if.AS20}, 32'h1);
        setup_chain(NIB_FASTRAM, 32'hFFFFFFFF, 1, 0);
        push_wr(24'hE80048, 8'h20, 8'hE0, 8'h02, 16'h13D8);
        push_done(3'd1, 1'b1, 8'hFF, 8'h00, 16'h0000);
        exp_done_lat = 105;
        start_run();
        wait_done(400);
        exp_done_lat = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
